// File: rtl/fp_execute_stage3.sv
// fp_execute_stage3
//   Third stage of the floating-point / integer-multiply pipeline. Adds or
//   subtracts the aligned significands of each lane, counts the leading zeros
//   of that result for the normalize stage, and registers the multiply product
//   and every per-lane side field through one pipeline register. An
//   instruction entering this stage is squashed when writeback rolls back the
//   same thread from the memory pipeline.
//
// Ports
//   clk, reset (async, active-low)
//   wb_rollback_en / wb_rollback_thread_idx / wb_rollback_pipeline : rollback request
//   fx2_* : stage-2 instruction, control and per-lane datapath inputs
//   fx3_* : registered outputs to the normalize/round stage
//   fx3_add_significand : per-lane 32-bit sum/difference
//   fx3_add_lz          : per-lane leading-zero count (0..32)
module fp_execute_stage3 #(
  parameter int NUM_LANES = 16,
  localparam int INST_W     = 64,
  localparam int THREAD_W   = 2,
  localparam int PIPE_W     = 2,
  localparam int SUBCYCLE_W = $clog2(NUM_LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_rollback_en,
  input  logic [THREAD_W-1:0]       wb_rollback_thread_idx,
  input  logic [PIPE_W-1:0]         wb_rollback_pipeline,
  input  logic                      fx2_instruction_valid,
  input  logic [INST_W-1:0]         fx2_instruction,
  input  logic [NUM_LANES-1:0]      fx2_mask_value,
  input  logic [THREAD_W-1:0]       fx2_thread_idx,
  input  logic [SUBCYCLE_W-1:0]     fx2_subcycle,
  input  logic [NUM_LANES-1:0]      fx2_result_inf,
  input  logic [NUM_LANES-1:0]      fx2_result_nan,
  input  logic [NUM_LANES-1:0]      fx2_equal,
  input  logic [NUM_LANES-1:0]      fx2_logical_subtract,
  input  logic [NUM_LANES-1:0]      fx2_add_result_sign,
  input  logic [NUM_LANES-1:0]      fx2_guard,
  input  logic [NUM_LANES-1:0]      fx2_round,
  input  logic [NUM_LANES-1:0]      fx2_sticky,
  input  logic [NUM_LANES-1:0]      fx2_mul_underflow,
  input  logic [NUM_LANES-1:0]      fx2_mul_sign,
  input  logic [NUM_LANES*6-1:0]    fx2_ftoi_lshift,
  input  logic [NUM_LANES*32-1:0]   fx2_significand_le,
  input  logic [NUM_LANES*32-1:0]   fx2_significand_se,
  input  logic [NUM_LANES*8-1:0]    fx2_add_exponent,
  input  logic [NUM_LANES*8-1:0]    fx2_mul_exponent,
  input  logic [NUM_LANES*64-1:0]   fx2_significand_product,
  output logic                      fx3_instruction_valid,
  output logic [INST_W-1:0]         fx3_instruction,
  output logic [NUM_LANES-1:0]      fx3_mask_value,
  output logic [THREAD_W-1:0]       fx3_thread_idx,
  output logic [SUBCYCLE_W-1:0]     fx3_subcycle,
  output logic [NUM_LANES-1:0]      fx3_result_inf,
  output logic [NUM_LANES-1:0]      fx3_result_nan,
  output logic [NUM_LANES-1:0]      fx3_equal,
  output logic [NUM_LANES-1:0]      fx3_logical_subtract,
  output logic [NUM_LANES-1:0]      fx3_add_result_sign,
  output logic [NUM_LANES-1:0]      fx3_guard,
  output logic [NUM_LANES-1:0]      fx3_round,
  output logic [NUM_LANES-1:0]      fx3_sticky,
  output logic [NUM_LANES-1:0]      fx3_mul_underflow,
  output logic [NUM_LANES-1:0]      fx3_mul_sign,
  output logic [NUM_LANES*6-1:0]    fx3_ftoi_lshift,
  output logic [NUM_LANES*8-1:0]    fx3_add_exponent,
  output logic [NUM_LANES*8-1:0]    fx3_mul_exponent,
  output logic [NUM_LANES*64-1:0]   fx3_significand_product,
  output logic [NUM_LANES*32-1:0]   fx3_add_significand,
  output logic [NUM_LANES*6-1:0]    fx3_add_lz
);

  localparam logic [PIPE_W-1:0] PIPE_MEM = 2'd0;

  // On a logical subtract the bits shifted out of the smaller operand during
  // alignment make it slightly larger than its truncated value, so one extra
  // unit is borrowed whenever any of them was set.
  function automatic logic [31:0] add_significands(input logic [31:0] le,
                                                   input logic [31:0] se,
                                                   input logic        sub,
                                                   input logic        borrow);
    if (sub)
      return le - se - {31'd0, borrow};
    else
      return le + se;
  endfunction

  // Scans upward so the highest set bit is the last one to update the count.
  function automatic logic [5:0] count_leading_zeros(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i])
        n = 6'(31 - i);
    return n;
  endfunction

  logic [NUM_LANES*32-1:0] sum_p0;
  logic [NUM_LANES*6-1:0]  lz_p0;
  logic                    squash_p0;
  logic                    vld_p0;

  always_comb begin
    sum_p0 = '0;
    lz_p0  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      logic [31:0] s;
      s = add_significands(fx2_significand_le[l*32 +: 32],
                           fx2_significand_se[l*32 +: 32],
                           fx2_logical_subtract[l],
                           fx2_guard[l] | fx2_round[l] | fx2_sticky[l]);
      sum_p0[l*32 +: 32] = s;
      lz_p0[l*6 +: 6]    = count_leading_zeros(s);
    end
  end

  assign squash_p0 = wb_rollback_en
                  && (wb_rollback_thread_idx == fx2_thread_idx)
                  && (wb_rollback_pipeline == PIPE_MEM);
  assign vld_p0 = fx2_instruction_valid && !squash_p0;

  // ---- stage boundary: fx2 -> fx3 ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fx3_instruction_valid   <= 1'b0;
      fx3_instruction         <= '0;
      fx3_mask_value          <= '0;
      fx3_thread_idx          <= '0;
      fx3_subcycle            <= '0;
      fx3_result_inf          <= '0;
      fx3_result_nan          <= '0;
      fx3_equal               <= '0;
      fx3_logical_subtract    <= '0;
      fx3_add_result_sign     <= '0;
      fx3_guard               <= '0;
      fx3_round               <= '0;
      fx3_sticky              <= '0;
      fx3_mul_underflow       <= '0;
      fx3_mul_sign            <= '0;
      fx3_ftoi_lshift         <= '0;
      fx3_add_exponent        <= '0;
      fx3_mul_exponent        <= '0;
      fx3_significand_product <= '0;
      fx3_add_significand     <= '0;
      fx3_add_lz              <= '0;
    end else begin
      fx3_instruction_valid   <= vld_p0;
      fx3_instruction         <= fx2_instruction;
      fx3_mask_value          <= fx2_mask_value;
      fx3_thread_idx          <= fx2_thread_idx;
      fx3_subcycle            <= fx2_subcycle;
      fx3_result_inf          <= fx2_result_inf;
      fx3_result_nan          <= fx2_result_nan;
      fx3_equal               <= fx2_equal;
      fx3_logical_subtract    <= fx2_logical_subtract;
      fx3_add_result_sign     <= fx2_add_result_sign;
      fx3_guard               <= fx2_guard;
      fx3_round               <= fx2_round;
      fx3_sticky              <= fx2_sticky;
      fx3_mul_underflow       <= fx2_mul_underflow;
      fx3_mul_sign            <= fx2_mul_sign;
      fx3_ftoi_lshift         <= fx2_ftoi_lshift;
      fx3_add_exponent        <= fx2_add_exponent;
      fx3_mul_exponent        <= fx2_mul_exponent;
      fx3_significand_product <= fx2_significand_product;
      fx3_add_significand     <= sum_p0;
      fx3_add_lz              <= lz_p0;
    end
  end

endmodule

// File: tb/tb_fp_execute_stage3.sv
// tb_fp_execute_stage3
//   Drives randomized and directed stage-2 traffic into fp_execute_stage3 and
//   compares every registered output against a behavioural model of the stage.
module tb_fp_execute_stage3;

  localparam int NL = 16;

  logic clk = 1'b0;
  logic reset;
  logic wb_rollback_en;
  logic [1:0] wb_rollback_thread_idx, wb_rollback_pipeline;
  logic fx2_instruction_valid;
  logic [63:0] fx2_instruction;
  logic [NL-1:0] fx2_mask_value;
  logic [1:0] fx2_thread_idx;
  logic [3:0] fx2_subcycle;
  logic [NL-1:0] fx2_result_inf, fx2_result_nan, fx2_equal, fx2_logical_subtract,
                 fx2_add_result_sign, fx2_guard, fx2_round, fx2_sticky,
                 fx2_mul_underflow, fx2_mul_sign;
  logic [NL*6-1:0] fx2_ftoi_lshift;
  logic [NL*32-1:0] fx2_significand_le, fx2_significand_se;
  logic [NL*8-1:0] fx2_add_exponent, fx2_mul_exponent;
  logic [NL*64-1:0] fx2_significand_product;

  logic fx3_instruction_valid;
  logic [63:0] fx3_instruction;
  logic [NL-1:0] fx3_mask_value;
  logic [1:0] fx3_thread_idx;
  logic [3:0] fx3_subcycle;
  logic [NL-1:0] fx3_result_inf, fx3_result_nan, fx3_equal, fx3_logical_subtract,
                 fx3_add_result_sign, fx3_guard, fx3_round, fx3_sticky,
                 fx3_mul_underflow, fx3_mul_sign;
  logic [NL*6-1:0] fx3_ftoi_lshift;
  logic [NL*8-1:0] fx3_add_exponent, fx3_mul_exponent;
  logic [NL*64-1:0] fx3_significand_product;
  logic [NL*32-1:0] fx3_add_significand;
  logic [NL*6-1:0] fx3_add_lz;

  int checks = 0;
  int failures = 0;

  // expected values captured from the inputs presented before a clock edge
  logic             exp_valid;
  logic [NL*32-1:0] exp_sum;
  logic [NL*6-1:0]  exp_lz;
  logic [63:0]      exp_inst;
  logic [NL-1:0]    exp_mask, exp_flags [10];
  logic [1:0]       exp_thread;
  logic [3:0]       exp_subcycle;
  logic [NL*6-1:0]  exp_ftoi;
  logic [NL*8-1:0]  exp_aexp, exp_mexp;
  logic [NL*64-1:0] exp_prod;

  fp_execute_stage3 #(.NUM_LANES(NL)) dut (
    .clk(clk), .reset(reset),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pipeline(wb_rollback_pipeline),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
    .fx2_result_inf(fx2_result_inf), .fx2_result_nan(fx2_result_nan), .fx2_equal(fx2_equal),
    .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_guard(fx2_guard), .fx2_round(fx2_round), .fx2_sticky(fx2_sticky),
    .fx2_mul_underflow(fx2_mul_underflow), .fx2_mul_sign(fx2_mul_sign),
    .fx2_ftoi_lshift(fx2_ftoi_lshift), .fx2_significand_le(fx2_significand_le),
    .fx2_significand_se(fx2_significand_se), .fx2_add_exponent(fx2_add_exponent),
    .fx2_mul_exponent(fx2_mul_exponent), .fx2_significand_product(fx2_significand_product),
    .fx3_instruction_valid(fx3_instruction_valid), .fx3_instruction(fx3_instruction),
    .fx3_mask_value(fx3_mask_value), .fx3_thread_idx(fx3_thread_idx), .fx3_subcycle(fx3_subcycle),
    .fx3_result_inf(fx3_result_inf), .fx3_result_nan(fx3_result_nan), .fx3_equal(fx3_equal),
    .fx3_logical_subtract(fx3_logical_subtract), .fx3_add_result_sign(fx3_add_result_sign),
    .fx3_guard(fx3_guard), .fx3_round(fx3_round), .fx3_sticky(fx3_sticky),
    .fx3_mul_underflow(fx3_mul_underflow), .fx3_mul_sign(fx3_mul_sign),
    .fx3_ftoi_lshift(fx3_ftoi_lshift), .fx3_add_exponent(fx3_add_exponent),
    .fx3_mul_exponent(fx3_mul_exponent), .fx3_significand_product(fx3_significand_product),
    .fx3_add_significand(fx3_add_significand), .fx3_add_lz(fx3_add_lz)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference: plain integer arithmetic modulo 2^32, and leading zeros as
  // 32 minus the bit length of the value
  function automatic logic [31:0] ref_sum(input longint le, input longint se,
                                          input bit sub, input bit g, input bit r, input bit s);
    longint t;
    longint b;
    b = (g || r || s) ? 1 : 0;
    t = sub ? (le - se - b) : (le + se);
    t = t % 64'sd4294967296;
    if (t < 0) t = t + 64'sd4294967296;
    return t[31:0];
  endfunction

  function automatic logic [5:0] ref_lz(input logic [31:0] v);
    int len;
    len = 0;
    while (v != 0) begin
      v = v >> 1;
      len++;
    end
    return 6'(32 - len);
  endfunction

  task automatic randomize_inputs();
    fx2_instruction_valid = 1'b1;
    fx2_instruction = {$urandom, $urandom};
    fx2_mask_value = NL'($urandom);
    fx2_thread_idx = 2'($urandom);
    fx2_subcycle = 4'($urandom);
    fx2_result_inf = NL'($urandom);  fx2_result_nan = NL'($urandom);
    fx2_equal = NL'($urandom);       fx2_logical_subtract = NL'($urandom);
    fx2_add_result_sign = NL'($urandom);
    fx2_guard = NL'($urandom);       fx2_round = NL'($urandom);
    fx2_sticky = NL'($urandom);      fx2_mul_underflow = NL'($urandom);
    fx2_mul_sign = NL'($urandom);
    for (int l = 0; l < NL; l++) begin
      fx2_ftoi_lshift[l*6 +: 6] = 6'($urandom);
      // shorten some operands so small sums and large leading-zero counts occur
      fx2_significand_le[l*32 +: 32] = $urandom >> $urandom_range(0, 31);
      fx2_significand_se[l*32 +: 32] = $urandom >> $urandom_range(0, 31);
      fx2_add_exponent[l*8 +: 8] = 8'($urandom);
      fx2_mul_exponent[l*8 +: 8] = 8'($urandom);
      fx2_significand_product[l*64 +: 64] = {$urandom, $urandom};
    end
    wb_rollback_en = 1'b0;
    wb_rollback_thread_idx = 2'($urandom);
    wb_rollback_pipeline = 2'($urandom_range(0, 2));
  endtask

  task automatic set_lane(input int l, input logic [31:0] le, input logic [31:0] se,
                          input bit sub, input bit g, input bit r, input bit s);
    fx2_significand_le[l*32 +: 32] = le;
    fx2_significand_se[l*32 +: 32] = se;
    fx2_logical_subtract[l] = sub;
    fx2_guard[l] = g;
    fx2_round[l] = r;
    fx2_sticky[l] = s;
  endtask

  task automatic model();
    // an instruction is dropped only by a memory-pipeline rollback (encoding 0)
    // aimed at its own thread
    exp_valid = fx2_instruction_valid &&
                !(wb_rollback_en && wb_rollback_pipeline == 2'd0 &&
                  wb_rollback_thread_idx == fx2_thread_idx);
    for (int l = 0; l < NL; l++) begin
      exp_sum[l*32 +: 32] = ref_sum(longint'(fx2_significand_le[l*32 +: 32]),
                                    longint'(fx2_significand_se[l*32 +: 32]),
                                    fx2_logical_subtract[l], fx2_guard[l],
                                    fx2_round[l], fx2_sticky[l]);
      exp_lz[l*6 +: 6] = ref_lz(exp_sum[l*32 +: 32]);
    end
    exp_inst = fx2_instruction;  exp_mask = fx2_mask_value;
    exp_thread = fx2_thread_idx; exp_subcycle = fx2_subcycle;
    exp_flags[0] = fx2_result_inf;    exp_flags[1] = fx2_result_nan;
    exp_flags[2] = fx2_equal;         exp_flags[3] = fx2_logical_subtract;
    exp_flags[4] = fx2_add_result_sign; exp_flags[5] = fx2_guard;
    exp_flags[6] = fx2_round;         exp_flags[7] = fx2_sticky;
    exp_flags[8] = fx2_mul_underflow; exp_flags[9] = fx2_mul_sign;
    exp_ftoi = fx2_ftoi_lshift; exp_aexp = fx2_add_exponent;
    exp_mexp = fx2_mul_exponent; exp_prod = fx2_significand_product;
  endtask

  task automatic check_all();
    chk("valid", 1024'(fx3_instruction_valid), 1024'(exp_valid));
    chk("add_significand", 1024'(fx3_add_significand), 1024'(exp_sum));
    chk("add_lz", 1024'(fx3_add_lz), 1024'(exp_lz));
    chk("instruction", 1024'(fx3_instruction), 1024'(exp_inst));
    chk("mask/thread/subcycle", 1024'({fx3_mask_value, fx3_thread_idx, fx3_subcycle}),
        1024'({exp_mask, exp_thread, exp_subcycle}));
    chk("flags", 1024'({fx3_result_inf, fx3_result_nan, fx3_equal, fx3_logical_subtract,
                        fx3_add_result_sign, fx3_guard, fx3_round, fx3_sticky,
                        fx3_mul_underflow, fx3_mul_sign}),
        1024'({exp_flags[0], exp_flags[1], exp_flags[2], exp_flags[3], exp_flags[4],
               exp_flags[5], exp_flags[6], exp_flags[7], exp_flags[8], exp_flags[9]}));
    chk("ftoi/exponents", 1024'({fx3_ftoi_lshift, fx3_add_exponent, fx3_mul_exponent}),
        1024'({exp_ftoi, exp_aexp, exp_mexp}));
    chk("product", 1024'(fx3_significand_product), 1024'(exp_prod));
  endtask

  // inputs are changed 1 time unit after a rising edge; outputs are read there too
  task automatic step();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 1024'(fx3_instruction_valid), '0);
    chk({tag, "_sum_lz"}, 1024'({fx3_add_significand, fx3_add_lz}), '0);
    chk({tag, "_product"}, 1024'(fx3_significand_product), '0);
    chk({tag, "_ctrl"}, 1024'({fx3_instruction, fx3_mask_value, fx3_thread_idx, fx3_subcycle,
                               fx3_ftoi_lshift, fx3_add_exponent, fx3_mul_exponent}), '0);
    chk({tag, "_flags"}, 1024'({fx3_result_inf, fx3_result_nan, fx3_equal, fx3_logical_subtract,
                                fx3_add_result_sign, fx3_guard, fx3_round, fx3_sticky,
                                fx3_mul_underflow, fx3_mul_sign}), '0);
  endtask

  initial begin
    reset = 1'b0;
    randomize_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;

    // lane 0 add
    randomize_inputs();
    set_lane(0, 32'h0080_0000, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lane0_add_sum", 1024'(fx3_add_significand[31:0]), 1024'(32'h00C0_0000));
    chk("lane0_add_lz", 1024'(fx3_add_lz[5:0]), 1024'(6'd8));
    chk("lane0_add_valid", 1024'(fx3_instruction_valid), 1024'(1'b1));

    // subtract with borrow from sticky, then without
    randomize_inputs();
    set_lane(0, 32'h0080_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("sub_borrow_sum", 1024'(fx3_add_significand[31:0]), 1024'(32'h007F_FFFE));
    chk("sub_borrow_lz", 1024'(fx3_add_lz[5:0]), 1024'(6'd9));
    randomize_inputs();
    set_lane(0, 32'h0080_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("sub_noborrow_sum", 1024'(fx3_add_significand[31:0]), 1024'(32'h007F_FFFF));
    chk("sub_noborrow_lz", 1024'(fx3_add_lz[5:0]), 1024'(6'd9));

    // zero result; guard alone and round alone also borrow
    randomize_inputs();
    set_lane(0, 32'h00A0_0000, 32'h00A0_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    set_lane(1, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0);
    set_lane(2, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
    set_lane(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("zero_sum", 1024'(fx3_add_significand[31:0]), 1024'(32'h0));
    chk("zero_lz", 1024'(fx3_add_lz[5:0]), 1024'(6'd32));
    chk("guard_borrow", 1024'(fx3_add_significand[63:32]), 1024'(32'h0000_000E));
    chk("round_borrow", 1024'(fx3_add_significand[95:64]), 1024'(32'h0000_000E));
    chk("add_wrap", 1024'({fx3_add_significand[127:96], fx3_add_lz[23:18]}),
        1024'({32'h0, 6'd32}));

    // rollbacks
    randomize_inputs();
    fx2_thread_idx = 2'd2;
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = 2'd0;
    step();
    chk("rollback_match", 1024'(fx3_instruction_valid), 1024'(1'b0));
    randomize_inputs();
    fx2_thread_idx = 2'd2;
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1; wb_rollback_pipeline = 2'd0;
    step();
    chk("rollback_other_thread", 1024'(fx3_instruction_valid), 1024'(1'b1));
    randomize_inputs();
    fx2_thread_idx = 2'd2;
    wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd2; wb_rollback_pipeline = 2'd1;
    step();
    chk("rollback_int_pipe", 1024'(fx3_instruction_valid), 1024'(1'b1));

    // product passthrough on lane 15
    randomize_inputs();
    fx2_significand_product[15*64 +: 64] = 64'hFFFF_FFFE_0000_0001;
    step();
    chk("product_lane15", 1024'(fx3_significand_product[15*64 +: 64]),
        1024'(64'hFFFF_FFFE_0000_0001));

    // randomized traffic with random rollbacks and valid
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      fx2_instruction_valid = 1'($urandom);
      wb_rollback_en = 1'($urandom);
      step();
    end

    // reset asserted between edges while a valid instruction is in flight
    randomize_inputs();
    step();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    reset = 1'b1;
    randomize_inputs();
    #1;
    chk("post_release_preedge", 1024'(fx3_instruction_valid), 1024'(1'b0));
    step();
    chk("post_release_valid", 1024'(fx3_instruction_valid), 1024'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
